// File: rtl/fm_wm_buffer_if.sv
// rtl/fm_wm_buffer_if.sv - fill/read bus between the vector multiplier, the FM x WM buffer and its reader
//
// Signals:
//   start     one-cycle pulse that (re)starts a fill frame
//   fm_wm_in  dot-product word from the vector multiplier
//   in_valid  fm_wm_in is valid
//   in_ready  buffer accepts fm_wm_in (driven by the buffer)
//   wr_row    row index of the next element to be written (driven by the buffer)
//   wr_col    column index of the next element to be written (driven by the buffer)
//   done      one-cycle pulse when the matrix is complete (driven by the buffer)
//   rd_en     read request
//   rd_row    read row address
//   rd_col    read column address
//   rd_data   registered read data (driven by the buffer)
//   rd_valid  rd_data valid (driven by the buffer)
interface fm_wm_buffer_if #(
  parameter int DOT_PROD_WIDTH = 16,
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int ROW_W          = $clog2(FEATURE_ROWS),
  parameter int COL_W          = $clog2(WEIGHT_COLS)
);
  logic                      start;
  logic [DOT_PROD_WIDTH-1:0] fm_wm_in;
  logic                      in_valid;
  logic                      in_ready;
  logic [ROW_W-1:0]          wr_row;
  logic [COL_W-1:0]          wr_col;
  logic                      done;
  logic                      rd_en;
  logic [ROW_W-1:0]          rd_row;
  logic [COL_W-1:0]          rd_col;
  logic [DOT_PROD_WIDTH-1:0] rd_data;
  logic                      rd_valid;

  modport master (
    output start, fm_wm_in, in_valid, rd_en, rd_row, rd_col,
    input  in_ready, wr_row, wr_col, done, rd_data, rd_valid
  );

  modport slave (
    input  start, fm_wm_in, in_valid, rd_en, rd_row, rd_col,
    output in_ready, wr_row, wr_col, done, rd_data, rd_valid
  );
endinterface

// File: rtl/fm_wm_buffer.sv
// rtl/fm_wm_buffer.sv - row-major FM x WM dot-product matrix buffer with registered random read
//
// Ports:
//   clk      sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      fm_wm_buffer_if.slave: fill handshake, write indices, done pulse, read port
module fm_wm_buffer #(
  parameter int DOT_PROD_WIDTH = 16,
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int ROW_W          = $clog2(FEATURE_ROWS),
  parameter int COL_W          = $clog2(WEIGHT_COLS)
) (
  input logic           clk,
  input logic           reset_n,
  fm_wm_buffer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WEIGHT_COLS - 1);

  state_t                    state_q, state_d;
  logic [ROW_W-1:0]          wr_row_q;
  logic [COL_W-1:0]          wr_col_q;
  logic                      done_q;
  logic                      rd_valid_q;
  logic [DOT_PROD_WIDTH-1:0] rd_data_q;
  logic [DOT_PROD_WIDTH-1:0] mem [FEATURE_ROWS][WEIGHT_COLS];

  logic xfer;
  logic last_elem;
  logic rd_in_range;

  // A start in FILL aborts the frame, so a same-cycle transfer is dropped.
  assign xfer        = bus.in_valid && (state_q == FILL) && !bus.start;
  assign last_elem   = (wr_row_q == LAST_ROW) && (wr_col_q == LAST_COL);
  assign rd_in_range = (32'(bus.rd_row) < FEATURE_ROWS) && (32'(bus.rd_col) < WEIGHT_COLS);

  assign bus.in_ready = (state_q == FILL);
  assign bus.wr_row   = wr_row_q;
  assign bus.wr_col   = wr_col_q;
  assign bus.done     = done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = FILL;
      FILL:    if (xfer && last_elem) state_d = FULL;
      FULL:    if (bus.start) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  // Write indices, storage and completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_row_q <= '0;
      wr_col_q <= '0;
      done_q   <= 1'b0;
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else begin
      done_q <= xfer && last_elem;
      if (bus.start) begin
        wr_row_q <= '0;
        wr_col_q <= '0;
      end else if (xfer) begin
        mem[wr_row_q][wr_col_q] <= bus.fm_wm_in;
        if (wr_col_q == LAST_COL) begin
          wr_col_q <= '0;
          wr_row_q <= last_elem ? '0 : wr_row_q + 1'b1;
        end else begin
          wr_col_q <= wr_col_q + 1'b1;
        end
      end
    end
  end

  // Read port: only FULL honours rd_en; otherwise rd_data keeps its last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (bus.rd_en && (state_q == FULL)) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= rd_in_range ? mem[bus.rd_row][bus.rd_col] : '0;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

endmodule

// File: doc/fm_wm_buffer.md
FM_WM_BUFFER -- requirements
Module: fm_wm_buffer

Interface
REQ-001 SHALL have parameter DOT_PROD_WIDTH, default 16: width of each dot-product word.
REQ-002 SHALL have parameter FEATURE_ROWS, default 6: number of rows in the FM x WM matrix.
REQ-003 SHALL have parameter WEIGHT_COLS, default 3: number of columns in the FM x WM matrix.
REQ-004 SHALL have parameter ROW_W, default $clog2(FEATURE_ROWS): width of the row index.
REQ-005 SHALL have parameter COL_W, default $clog2(WEIGHT_COLS): width of the column index.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  one-cycle pulse that begins a new fill frame.
REQ-009 SHALL have port fm_wm_in  input  DOT_PROD_WIDTH  dot-product result from the vector multiplier.
REQ-010 SHALL have port in_valid  input  1  fm_wm_in is valid this cycle.
REQ-011 SHALL have port in_ready  output  1  buffer accepts fm_wm_in this cycle.
REQ-012 SHALL have port wr_row  output  ROW_W  row index of the next element to be written; selects the feature row upstream.
REQ-013 SHALL have port wr_col  output  COL_W  column index of the next element to be written; selects the weight column upstream.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the matrix is complete.
REQ-015 SHALL have port rd_en  input  1  read request.
REQ-016 SHALL have port rd_row  input  ROW_W  read row address.
REQ-017 SHALL have port rd_col  input  COL_W  read column address.
REQ-018 SHALL have port rd_data  output  DOT_PROD_WIDTH  registered read data.
REQ-019 SHALL have port rd_valid  output  1  rd_data is valid this cycle.

Function
REQ-020 SHALL implement a three-state FSM: IDLE, FILL, FULL.
REQ-021 IDLE: in_ready=0; start -> FILL, wr_row=0, wr_col=0.
REQ-022 FILL: in_ready=1; a transfer is in_valid && in_ready; it writes fm_wm_in to storage[wr_row][wr_col] on that edge.
REQ-023 Write order is row-major: wr_col increments per transfer; at WEIGHT_COLS-1 wr_col wraps to 0 and wr_row increments.
REQ-024 Transfer at (FEATURE_ROWS-1, WEIGHT_COLS-1) -> FULL, wr_row/wr_col return to 0, done=1 for exactly the next cycle.
REQ-025 in_valid=0 in FILL: no write, indices hold.
REQ-026 start in FILL (mid-frame): abort; indices reset to 0, any same-cycle transfer discarded, remain FILL; previously written words retained until overwritten.
REQ-027 start in FULL: -> FILL, indices 0; storage retained until overwritten.
REQ-028 Data is stored unmodified at full DOT_PROD_WIDTH; no saturation or truncation.
REQ-029 Reads are honoured only in FULL: rd_en=1 -> next cycle rd_valid=1, rd_data=storage[rd_row][rd_col].
REQ-030 Read with rd_row>=FEATURE_ROWS or rd_col>=WEIGHT_COLS -> next cycle rd_valid=1, rd_data=0.
REQ-031 rd_en in IDLE/FILL -> next cycle rd_valid=0, rd_data holds its previous value.
REQ-032 rd_en and start in the same FULL cycle: the read completes (rd_valid=1 next cycle); the FSM enters FILL.
REQ-033 Read latency is one cycle, back-to-back reads every cycle; no combinational path from rd_* to rd_data.
REQ-034 in_ready SHALL be a function of state only (no combinational dependence on in_valid).

Reset
REQ-035 reset_n=0 asynchronously forces: state=IDLE, wr_row=0, wr_col=0, in_ready=0, done=0, rd_valid=0, rd_data=0, storage all 0.
REQ-036 Reset mid-FILL discards the partial frame; after release, start is needed to resume.
REQ-037 Deassertion SHALL be sampled synchronously; the first active edge after release sees IDLE.

Verification
REQ-038 reset, start, 18 back-to-back transfers of values 1..18 -> done on the cycle after the 18th; read (2,1) -> rd_data=8 one cycle later.
REQ-039 FILL with in_valid toggling 1,0,1,0 -> wr_col advances only on the valid cycles; the final matrix matches a row-major reference.
REQ-040 start after the 7th transfer, then 18 transfers of 0x0100+k -> storage[0][0]=0x0100, done once.
REQ-041 FULL, rd_en with rd_row=6 -> rd_valid=1, rd_data=0; rd_en in FILL -> rd_valid=0.
REQ-042 reset_n low for one non-edge interval mid-FILL -> outputs clear immediately; IDLE after release; in_ready=0.
REQ-043 fm_wm_in=0xFFFF stored at (5,2) -> read back 0xFFFF, with no width loss.
